// File: rtl/apb_cfg_master_if.sv
// Command/response and APB bus bundle for apb_cfg_master.
// master: the apb_cfg_master view. slave: the command source / APB responder view.
interface apb_cfg_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // response side
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  // APB bus
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_cfg_master.sv
// apb_cfg_master: single-command APB requester for a small config register file.
// One command in flight: IDLE -> SETUP -> ACCESS (wait on pready) -> RESP -> IDLE.
// Optional feature macro APB_TIMEOUT_EN: bounds ACCESS to TIMEOUT_CYCLES wait cycles.
module apb_cfg_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  apb_cfg_master_if.master  ifc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;

  // A zero limit would time out before any access could complete.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("apb_cfg_master: TIMEOUT_CYCLES must be nonzero");
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;

  // Wait-cycle count including the current ACCESS cycle.
  assign wait_cnt_inc = wait_cnt + CNT_W'(1);
`else
  // No timeout hardware in this build.
  assign ifc.rsp_timeout = 1'b0;
`endif

  // Ready only in IDLE; forced low while reset is held so it tracks preset asynchronously.
  assign ifc.cmd_ready = (state == IDLE) && !preset;

  // Transfer FSM; the APB address/data registers double as the latched command.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state         <= IDLE;
      ifc.psel      <= 1'b0;
      ifc.penable   <= 1'b0;
      ifc.pwrite    <= 1'b0;
      ifc.paddr     <= '0;
      ifc.pwdata    <= '0;
      ifc.rsp_valid <= 1'b0;
      ifc.rsp_rdata <= '0;
      ifc.rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      ifc.rsp_timeout <= 1'b0;
      wait_cnt        <= '0;
`endif
    end else begin
      ifc.rsp_valid <= 1'b0;
      ifc.rsp_rdata <= '0;
      ifc.rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      ifc.rsp_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ifc.cmd_valid) begin
            state      <= SETUP;
            ifc.psel   <= 1'b1;
            ifc.pwrite <= ifc.cmd_write;
            ifc.paddr  <= ifc.cmd_addr;
            ifc.pwdata <= ifc.cmd_write ? ifc.cmd_wdata : DATA_W'(0);
          end
        end
        SETUP: begin
          state       <= ACCESS;
          ifc.penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        ACCESS: begin
          if (ifc.pready) begin
            state         <= RESP;
            ifc.psel      <= 1'b0;
            ifc.penable   <= 1'b0;
            ifc.pwrite    <= 1'b0;
            ifc.paddr     <= '0;
            ifc.pwdata    <= '0;
            ifc.rsp_valid <= 1'b1;
            ifc.rsp_err   <= ifc.pslverr;
            ifc.rsp_rdata <= ifc.pwrite ? DATA_W'(0) : ifc.prdata;
`ifdef APB_TIMEOUT_EN
          end else if (wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
            state           <= RESP;
            wait_cnt        <= wait_cnt_inc;
            ifc.psel        <= 1'b0;
            ifc.penable     <= 1'b0;
            ifc.pwrite      <= 1'b0;
            ifc.paddr       <= '0;
            ifc.pwdata      <= '0;
            ifc.rsp_valid   <= 1'b1;
            ifc.rsp_err     <= 1'b1;
            ifc.rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt_inc;
`endif
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master: directed and random transfers against a timeline model.
module tb_apb_cfg_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic pclk;
  logic preset;
  int   checks;
  int   errors;

  apb_cfg_master_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  apb_cfg_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .ifc   (ifc)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Response expected from the transfer rules: ACCESS lasts waits+1 cycles unless the
  // timeout limit is hit first; reads return prdata, writes return 0.
  task automatic model(input bit wr, input logic [31:0] rd, input int waits, input bit slverr,
                       output int acc, output logic [31:0] erd, output bit eerr, output bit eto);
    acc  = waits + 1;
    erd  = wr ? 32'h0 : rd;
    eerr = slverr;
    eto  = 1'b0;
`ifdef APB_TIMEOUT_EN
    if (waits >= int'(TO)) begin
      acc  = int'(TO);
      erd  = 32'h0;
      eerr = 1'b1;
      eto  = 1'b1;
    end
`endif
  endtask

  // Random command traffic that must be ignored while a transfer is in flight.
  task automatic noise();
    ifc.cmd_valid = 1'($urandom);
    ifc.cmd_write = 1'($urandom);
    ifc.cmd_addr  = $urandom;
    ifc.cmd_wdata = $urandom;
  endtask

  task automatic quiet_cmd();
    ifc.cmd_valid = 1'b0;
    ifc.cmd_write = 1'b0;
    ifc.cmd_addr  = '0;
    ifc.cmd_wdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"},      ifc.psel, 0);
    check({tag, "_penable"},   ifc.penable, 0);
    check({tag, "_pwrite"},    ifc.pwrite, 0);
    check({tag, "_paddr"},     ifc.paddr, 0);
    check({tag, "_pwdata"},    ifc.pwdata, 0);
    check({tag, "_cmd_ready"}, ifc.cmd_ready, 0);
    check({tag, "_rsp_valid"}, ifc.rsp_valid, 0);
    check({tag, "_rsp_rdata"}, ifc.rsp_rdata, 0);
    check({tag, "_rsp_err"},   ifc.rsp_err, 0);
    check({tag, "_rsp_to"},    ifc.rsp_timeout, 0);
  endtask

  // Entered and left at a negedge in an IDLE cycle; handshake happens at the next posedge.
  task automatic do_xfer(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input bit slverr);
    int          acc;
    logic [31:0] erd;
    bit          eerr;
    bit          eto;
    logic [31:0] epw;
    model(wr, rdata, waits, slverr, acc, erd, eerr, eto);
    epw = wr ? wdata : 32'h0;

    check({tag, "_idle_ready"}, ifc.cmd_ready, 1);
    check({tag, "_idle_paddr"}, ifc.paddr, 0);
    check({tag, "_idle_psel"},  ifc.psel, 0);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = wr;
    ifc.cmd_addr  = addr;
    ifc.cmd_wdata = wdata;

    @(negedge pclk);
    noise();
    ifc.pready  = 1'b0;
    ifc.pslverr = 1'($urandom);
    check({tag, "_setup_psel"},    ifc.psel, 1);
    check({tag, "_setup_penable"}, ifc.penable, 0);
    check({tag, "_setup_paddr"},   ifc.paddr, addr);
    check({tag, "_setup_pwrite"},  ifc.pwrite, wr);
    check({tag, "_setup_pwdata"},  ifc.pwdata, epw);
    check({tag, "_setup_ready"},   ifc.cmd_ready, 0);

    for (int k = 0; k < acc; k++) begin
      @(negedge pclk);
      noise();
      check({tag, "_acc_psel"},    ifc.psel, 1);
      check({tag, "_acc_penable"}, ifc.penable, 1);
      check({tag, "_acc_paddr"},   ifc.paddr, addr);
      check({tag, "_acc_pwrite"},  ifc.pwrite, wr);
      check({tag, "_acc_pwdata"},  ifc.pwdata, epw);
      check({tag, "_acc_rspv"},    ifc.rsp_valid, 0);
      if (k == waits) begin
        ifc.pready  = 1'b1;
        ifc.pslverr = slverr;
        ifc.prdata  = rdata;
      end else begin
        ifc.pready  = 1'b0;
        ifc.pslverr = 1'($urandom);
        ifc.prdata  = $urandom;
      end
    end

    @(negedge pclk);
    noise();
    ifc.pready  = 1'b0;
    ifc.pslverr = 1'b0;
    ifc.prdata  = $urandom;
    check({tag, "_rsp_valid"},   ifc.rsp_valid, 1);
    check({tag, "_rsp_rdata"},   ifc.rsp_rdata, erd);
    check({tag, "_rsp_err"},     ifc.rsp_err, eerr);
    check({tag, "_rsp_timeout"}, ifc.rsp_timeout, eto);
    check({tag, "_rsp_psel"},    ifc.psel, 0);
    check({tag, "_rsp_penable"}, ifc.penable, 0);
    check({tag, "_rsp_ready"},   ifc.cmd_ready, 0);

    @(negedge pclk);
    quiet_cmd();
    check({tag, "_back_ready"}, ifc.cmd_ready, 1);
    check({tag, "_back_rspv"},  ifc.rsp_valid, 0);
    check({tag, "_back_psel"},  ifc.psel, 0);
  endtask

  // Start a read, stall ACCESS for n cycles with no response, then reset mid-ACCESS.
  task automatic stall_then_reset(input int n);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = 1'b0;
    ifc.cmd_addr  = 32'h4;
    ifc.cmd_wdata = 32'h0;
    @(negedge pclk);
    quiet_cmd();
    ifc.pready = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge pclk);
      ifc.pready = 1'b0;
      check("stall_psel",    ifc.psel, 1);
      check("stall_penable", ifc.penable, 1);
      check("stall_paddr",   ifc.paddr, 32'h4);
      check("stall_rspv",    ifc.rsp_valid, 0);
    end
    #2 preset = 1'b1;
    #1 check_all_zero("abort");
    @(negedge pclk);
    check_all_zero("abort_held");
    preset = 1'b0;
    #1 check("abort_release_ready", ifc.cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      check("abort_no_rsp",  ifc.rsp_valid, 0);
      check("abort_ready",   ifc.cmd_ready, 1);
      check("abort_no_psel", ifc.psel, 0);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    preset  = 1'b1;
    quiet_cmd();
    ifc.pready  = 1'b0;
    ifc.pslverr = 1'b0;
    ifc.prdata  = '0;

    // Reset state, held across clock edges.
    repeat (2) @(negedge pclk);
    check_all_zero("reset");
    preset = 1'b0;
    #1 check("reset_release_ready", ifc.cmd_ready, 1);
    @(negedge pclk);

    // Directed: zero-wait write, three-wait read, back to back.
    do_xfer("wr_ctrl", 1'b1, 32'h4, 32'h0000_0123, 32'hDEAD_BEEF, 0, 1'b0);
    do_xfer("rd_tx",   1'b0, 32'h0, 32'h1111_2222, 32'hA5A5_5A5A, 3, 1'b0);
    // Slave error on a write.
    do_xfer("wr_err",  1'b1, 32'h0, 32'h0000_00FF, 32'h0, 0, 1'b1);
    // Slave error on a read with waits.
    do_xfer("rd_err",  1'b0, 32'h4, 32'h0, 32'h1234_5678, 2, 1'b1);
    @(negedge pclk);

    // Random transfers with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      int gap;
      do_xfer("rand", 1'($urandom), ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h4,
              $urandom, $urandom, int'($urandom_range(0, 5)), 1'($urandom));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge pclk);
        check("gap_psel", ifc.psel, 0);
        check("gap_rspv", ifc.rsp_valid, 0);
      end
    end

`ifdef APB_TIMEOUT_EN
    // pready arriving on the limit cycle completes normally; one more wait times out.
    do_xfer("to_edge", 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, int'(TO) - 1, 1'b0);
    do_xfer("to_hit",  1'b0, 32'h4, 32'h0, 32'hCAFE_F00D, int'(TO), 1'b0);
    do_xfer("to_long", 1'b1, 32'h4, 32'h55, 32'h0, int'(TO) + 5, 1'b0);
    stall_then_reset(int'(TO) - 2);
`else
    // Without the timeout, ACCESS waits indefinitely.
    stall_then_reset(100);
`endif

    // Recovery after the aborted transfer.
    do_xfer("post_abort", 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
